dout_writer: RTL and testbench
==============================

// Module: dout_writer
// PURPOSE
//  Transmit side of the ADC serial DOUT interface: drdy (active-low), dclk, dout.
//  Shifts two DATA_W-bit two's-complement channel words out MSB-first, ch1 then ch2,
//  as one frame per start_i. Serves as an on-FPGA ADC emulator: drive a pmod loopback
//  into the reader path, and generate known-value stimulus for the filter/lock-in chain.
// PARAMETERS
//  DATA_W     24  bits per channel word; frame = 2*DATA_W bits
//  CLK_DIV    4   dclk half-period in clk cycles (>=1); dclk period = 2*CLK_DIV
//  DRDY_LEAD  8   clk cycles drdy is low with dclk low before the first dclk rise (>=1)
// PORTS
//  clk_i    in   1       system clock; only clock
//  reset_i  in   1       synchronous reset, active-high
//  start_i  in   1       frame request, sampled each cycle; accepted only when busy_o=0
//  ch1_i    in   DATA_W  channel-1 word, signed, captured on acceptance
//  ch2_i    in   DATA_W  channel-2 word, signed, captured on acceptance
//  drdy_o   out  1       frame-active strobe, low for the whole frame
//  dclk_o   out  1       serial clock; receiver samples dout_o on the rising edge
//  dout_o   out  1       serial data; changes only on the dclk falling edge
//  busy_o   out  1       1 while a frame is in progress
//  done_o   out  1       one-cycle pulse when the frame completes
// BEHAVIOUR
//  Reset: drdy_o=1, dclk_o=0, dout_o=0, busy_o=0, done_o=0. Shift register and counters
//   are cleared. Reset has priority over start_i.
//  States: IDLE -> LEAD -> HIGH <-> LOW -> IDLE. All outputs are registered.
//  IDLE: drdy=1, dclk=0, dout=0. A start_i sampled at edge T loads shreg={ch1_i,ch2_i}.
//   From T+1: drdy=0, busy=1, dout=shreg[2*DATA_W-1], state LEAD.
//  LEAD: dclk=0 for DRDY_LEAD cycles (T+1..T+DRDY_LEAD), then -> HIGH.
//  HIGH: dclk=1 for CLK_DIV cycles. At the falling edge: if bits remain, shift left,
//   dout=next bit, and -> LOW. After the last bit (2*DATA_W rising edges total), go to the
//   end-of-frame cycle.
//  LOW: dclk=0 for CLK_DIV cycles, then -> HIGH.
//  End-of-frame cycle (the last falling edge): dclk=0, drdy=1, dout=0, busy=0, done=1.
//   State is IDLE. A start_i sampled in this cycle is accepted, so drdy is high for
//   exactly 1 cycle between back-to-back frames; that is the minimum gap.
//  done_o cycle = T + 1 + DRDY_LEAD + (2*DATA_W-1)*2*CLK_DIV + CLK_DIV.
//   With the defaults this is T+389.
//  start_i while busy_o=1: ignored, not queued. Input changes during a frame have no
//   effect on it.
//  Bit counter: counts 0..2*DATA_W-1 and does not wrap within a frame. The half-period
//   counter reloads each phase. CLK_DIV=1 is legal.
//  Reset mid-frame: the next cycle shows reset values, done_o is not pulsed, and the
//   partial frame is abandoned. The next start_i behaves as from a cold reset.
//  No dclk edges and no dout changes occur while drdy=1.
// TESTING
//  1 ch1=0x123456, ch2=0xABCDEF, single start at T -> a sampling model (rising dclk while
//    drdy=0) recovers 0x123456, 0xABCDEF; exactly 48 rises; done_o only at T+389.
//  2 Loopback into the DOUT reader, ch1=0xFFFFFF, ch2=0x800000 -> reader ch1_o=-1,
//    ch2_o=-8388608, one tick_o per frame.
//  3 Second start_i at T+100 mid-frame -> ignored: 48 rises, one done_o, busy low at T+389.
//  4 start_i held high for 3 frames, data changed between frames -> drdy high exactly
//    1 cycle between frames; each frame carries the data present at its acceptance cycle.
//  5 reset_i at T+200 -> T+201: drdy=1, dclk=0, dout=0, busy=0, no done_o; a new frame
//    started at T+210 decodes correctly.
//  6 CLK_DIV=1, DRDY_LEAD=1, ch1=0x000001, ch2=0x7FFFFF -> done_o at T+97, values
//    recovered, dout stable at every rising dclk.

Source files
------------

// File: rtl/dout_writer.sv
// dout_writer: transmit side of the ADC serial DOUT interface (ADC emulator).
// Shifts {ch1_i, ch2_i} out MSB-first as one frame per accepted start_i.
// drdy_o is held low for the whole frame. dout_o changes only on dclk falling
// edges, so a receiver samples it on the dclk rising edge.
//
// Ports:
//   clk_i    in   system clock
//   reset_i  in   synchronous reset, active-high (priority over start_i)
//   start_i  in   frame request, accepted only while busy_o=0
//   ch1_i    in   channel-1 word (signed), captured on acceptance
//   ch2_i    in   channel-2 word (signed), captured on acceptance
//   drdy_o   out  frame-active strobe, active-low
//   dclk_o   out  serial clock
//   dout_o   out  serial data
//   busy_o   out  frame in progress
//   done_o   out  one-cycle pulse on the final dclk falling edge
module dout_writer #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned DRDY_LEAD = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] ch1_i,
  input  logic [DATA_W-1:0] ch2_i,
  output logic              drdy_o,
  output logic              dclk_o,
  output logic              dout_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned FRAME_W = 2 * DATA_W;
  localparam int unsigned CNT_MAX = (CLK_DIV > DRDY_LEAD) ? CLK_DIV : DRDY_LEAD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(DRDY_LEAD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, HIGH, LOW} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [BIT_W-1:0]   bitcnt, bitcnt_d;
  logic [FRAME_W-1:0] shreg, shreg_d;
  logic               drdy_d, dclk_d, dout_d, busy_d, done_d;
  logic               lead_end, half_end, last_bit;

  assign lead_end = (cnt == LEAD_LAST);
  assign half_end = (cnt == HALF_LAST);
  assign last_bit = (bitcnt == BIT_LAST);

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      drdy_o <= 1'b1;
      dclk_o <= 1'b0;
      dout_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_d;
      bitcnt <= bitcnt_d;
      shreg  <= shreg_d;
      drdy_o <= drdy_d;
      dclk_o <= dclk_d;
      dout_o <= dout_d;
      busy_o <= busy_d;
      done_o <= done_d;
    end
  end

  // Next state. The last falling edge returns straight to IDLE, so that
  // end-of-frame cycle can already accept the next start_i.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i)  state_nxt = LEAD;
      LEAD:    if (lead_end) state_nxt = HIGH;
      HIGH:    if (half_end) state_nxt = last_bit ? IDLE : LOW;
      LOW:     if (half_end) state_nxt = HIGH;
      default: state_nxt = IDLE;
    endcase
  end

  // Register inputs for outputs and datapath. Outputs are derived from the
  // state being entered so that they are registered yet aligned with it.
  always_comb begin
    shreg_d  = shreg;
    bitcnt_d = bitcnt;
    dout_d   = dout_o;
    if (state == IDLE && start_i) begin
      shreg_d  = {ch1_i, ch2_i};
      bitcnt_d = '0;
      dout_d   = shreg_d[FRAME_W-1];
    end else if (state == HIGH && state_nxt == LOW) begin
      shreg_d  = shreg << 1;
      bitcnt_d = bitcnt + BIT_W'(1);
      dout_d   = shreg_d[FRAME_W-1];
    end else if (state_nxt == IDLE) begin
      dout_d   = 1'b0;
    end
    // Phase counter restarts on every state change and rests at zero in IDLE.
    cnt_d  = (state_nxt == state && state != IDLE) ? cnt + CNT_W'(1) : '0;
    drdy_d = (state_nxt == IDLE);
    busy_d = (state_nxt != IDLE);
    dclk_d = (state_nxt == HIGH);
    done_d = (state == HIGH) && (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_dout_writer.sv
module tb_dout_writer;

  localparam int DW = 24;
  localparam int FW = 48;
  localparam int D0 = 4;
  localparam int L0 = 8;
  localparam int D1 = 1;
  localparam int L1 = 1;

  typedef struct packed {
    logic drdy;
    logic dclk;
    logic dout;
    logic busy;
    logic done;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start [2];
  logic [DW-1:0] ch1   [2];
  logic [DW-1:0] ch2   [2];
  logic          drdy  [2];
  logic          dclk  [2];
  logic          dout  [2];
  logic          busy  [2];
  logic          done  [2];

  dout_writer #(.DATA_W(DW), .CLK_DIV(D0), .DRDY_LEAD(L0)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start[0]), .ch1_i(ch1[0]), .ch2_i(ch2[0]),
    .drdy_o(drdy[0]), .dclk_o(dclk[0]), .dout_o(dout[0]), .busy_o(busy[0]), .done_o(done[0]));

  dout_writer #(.DATA_W(DW), .CLK_DIV(D1), .DRDY_LEAD(L1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start[1]), .ch1_i(ch1[1]), .ch2_i(ch2[1]),
    .drdy_o(drdy[1]), .dclk_o(dclk[1]), .dout_o(dout[1]), .busy_o(busy[1]), .done_o(done[1]));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // ---------------- behavioural model ----------------
  // Cycle label n is the clock period following edge n-1. A start sampled at
  // edge T gives offset o = n - T; outputs follow from o by plain arithmetic.
  int            ecnt = 0;
  bit            m_has [2] = '{1'b0, 1'b0};
  int            m_t   [2] = '{0, 0};
  logic [FW-1:0] m_w   [2];

  function automatic int lof(input int i);
    return (i == 0) ? L0 : L1;
  endfunction

  function automatic int dof(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic outs_t model_outs(input bit has, input int o, input logic [FW-1:0] w,
                                       input int lead, input int div);
    outs_t r;
    int    f, p, idx;
    r      = '0;
    r.drdy = 1'b1;
    f      = 1 + lead + (FW - 1) * 2 * div + div;
    if (has && o >= 1 && o < f) begin
      p      = o - 1 - lead;
      r.drdy = 1'b0;
      r.busy = 1'b1;
      r.dclk = (p >= 0) && (((p / div) % 2) == 0);
      idx    = (p < 0) ? 0 : (p + div) / (2 * div);
      r.dout = w[FW-1-idx];
    end else if (has && o == f) begin
      r.done = 1'b1;
    end
    return r;
  endfunction

  function automatic bit model_busy(input int i, input int lbl);
    outs_t r;
    r = model_outs(m_has[i], lbl - m_t[i], m_w[i], lof(i), dof(i));
    return r.busy;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_has[i] <= 1'b0;
      end else if (start[i] && !model_busy(i, ecnt + 1)) begin
        m_has[i] <= 1'b1;
        m_t[i]   <= ecnt + 1;
        m_w[i]   <= {ch1[i], ch2[i]};
      end
    end
    ecnt <= ecnt + 1;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Serial receiver view of each DUT (rising dclk while drdy low).
  logic [FW-1:0] rx        [2];
  int            rises     [2] = '{0, 0};
  int            done_cnt  [2] = '{0, 0};
  logic [FW-1:0] last_word [2];
  int            last_rises[2] = '{0, 0};
  int            done_lbl  [2] = '{0, 0};
  int            hi_run    [2] = '{0, 0};
  int            last_gap  [2] = '{0, 0};
  logic          p_dclk    [2] = '{1'b0, 1'b0};
  logic          p_dout    [2] = '{1'b0, 1'b0};
  logic          p_drdy    [2] = '{1'b1, 1'b1};

  task automatic compare_and_sample();
    outs_t e, a;
    for (int i = 0; i < 2; i++) begin
      e = model_outs(m_has[i], ecnt + 1 - m_t[i], m_w[i], lof(i), dof(i));
      a = {drdy[i], dclk[i], dout[i], busy[i], done[i]};
      n_checks++;
      if (a !== e) begin
        n_err++;
        $display("FAIL model%0d cycle %0d: drdy/dclk/dout/busy/done got %b expected %b",
                 i, ecnt + 1, a, e);
      end
      if (!drdy[i] && p_drdy[i]) begin
        last_gap[i] = hi_run[i];
        rx[i]       = '0;
        rises[i]    = 0;
      end
      if (dclk[i] && !p_dclk[i] && !drdy[i]) begin
        check($sformatf("dout_stable_at_rise%0d", i), dout[i], p_dout[i]);
        rx[i]    = {rx[i][FW-2:0], dout[i]};
        rises[i] = rises[i] + 1;
      end
      hi_run[i] = drdy[i] ? hi_run[i] + 1 : 0;
      if (done[i]) begin
        done_cnt[i]   = done_cnt[i] + 1;
        last_word[i]  = rx[i];
        last_rises[i] = rises[i];
        done_lbl[i]   = ecnt + 1;
      end
      p_dclk[i] = dclk[i];
      p_dout[i] = dout[i];
      p_drdy[i] = drdy[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_and_sample();
    #1;
  endtask

  task automatic wait_done(input int i, input int n0, input string name);
    int k;
    k = 0;
    while (done_cnt[i] == n0 && k < 2000) begin
      tick();
      k++;
    end
    check({name, "_done_seen"}, done_cnt[i], n0 + 1);
  endtask

  task automatic start_frame(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             output int t);
    ch1[i]   = a;
    ch2[i]   = b;
    start[i] = 1'b1;
    t        = ecnt + 1;
    tick();
    start[i] = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int                 t, t1, n0;
    logic signed [DW-1:0] s;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      ch1[i]   = '0;
      ch2[i]   = '0;
    end
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_drdy", drdy[0], 1);
    check("rst_dclk", dclk[0], 0);
    check("rst_dout", dout[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    reset = 1'b0;
    repeat (2) tick();

    // 1: basic frame
    n0 = done_cnt[0];
    start_frame(0, 24'h123456, 24'hABCDEF, t);
    wait_done(0, n0, "t1");
    check("t1_word",  last_word[0], 48'h123456ABCDEF);
    check("t1_rises", last_rises[0], 48);
    check("t1_done_at", done_lbl[0] - t, 389);
    repeat (5) tick();

    // 2: reader-style signed decode
    n0 = done_cnt[0];
    start_frame(0, 24'hFFFFFF, 24'h800000, t);
    wait_done(0, n0, "t2");
    s = last_word[0][FW-1:DW];
    check("t2_ch1", s, -1);
    s = last_word[0][DW-1:0];
    check("t2_ch2", s, -8388608);
    repeat (5) tick();

    // 3: start while busy is ignored
    n0 = done_cnt[0];
    start_frame(0, 24'hC0FFEE, 24'h0BADF0, t);
    while (ecnt + 1 < t + 100) tick();
    start_frame(0, 24'h111111, 24'h222222, t1);
    wait_done(0, n0, "t3");
    check("t3_word",  last_word[0], 48'hC0FFEE0BADF0);
    check("t3_rises", last_rises[0], 48);
    check("t3_done_at", done_lbl[0] - t, 389);
    check("t3_busy_at_done", busy[0], 0);
    repeat (20) tick();
    check("t3_single_done", done_cnt[0], n0 + 1);

    // 4: start held high across three frames
    n0 = done_cnt[0];
    ch1[0] = 24'hA1A1A1; ch2[0] = 24'hA2A2A2;
    start[0] = 1'b1;
    t1 = ecnt + 1;
    tick();
    ch1[0] = 24'hB1B1B1; ch2[0] = 24'hB2B2B2;
    wait_done(0, n0, "t4a");
    check("t4a_word", last_word[0], 48'hA1A1A1A2A2A2);
    tick();
    ch1[0] = 24'hC1C1C1; ch2[0] = 24'hC2C2C2;
    wait_done(0, n0 + 1, "t4b");
    check("t4b_word", last_word[0], 48'hB1B1B1B2B2B2);
    check("t4b_gap", last_gap[0], 1);
    check("t4b_done_at", done_lbl[0] - t1, 778);
    tick();
    start[0] = 1'b0;
    wait_done(0, n0 + 2, "t4c");
    check("t4c_word", last_word[0], 48'hC1C1C1C2C2C2);
    check("t4c_gap", last_gap[0], 1);
    check("t4c_done_at", done_lbl[0] - t1, 1167);
    repeat (5) tick();

    // 5: reset mid-frame, then a clean frame
    n0 = done_cnt[0];
    start_frame(0, 24'h0F0F0F, 24'h5A5A5A, t);
    while (ecnt + 1 < t + 200) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_drdy", drdy[0], 1);
    check("t5_dclk", dclk[0], 0);
    check("t5_dout", dout[0], 0);
    check("t5_busy", busy[0], 0);
    check("t5_done", done[0], 0);
    while (ecnt + 1 < t + 210) tick();
    check("t5_no_done", done_cnt[0], n0);
    start_frame(0, 24'h13579B, 24'h2468AC, t);
    wait_done(0, n0, "t5");
    check("t5_word", last_word[0], 48'h13579B2468AC);
    check("t5_done_at", done_lbl[0] - t, 389);
    repeat (5) tick();

    // 6: fastest timing instance
    n0 = done_cnt[1];
    start_frame(1, 24'h000001, 24'h7FFFFF, t);
    wait_done(1, n0, "t6");
    check("t6_word",  last_word[1], 48'h0000017FFFFF);
    check("t6_rises", last_rises[1], 48);
    check("t6_done_at", done_lbl[1] - t, 97);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
